control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, opcode-dependent execute T3-T7, HALT.
// Optional macro CU_MULDIV_EN adds the mul/div execute sequence (otherwise both opcodes act as nop).
module control_unit (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        con_ff,
   input  logic        stop,
   output logic [8:0]  ld_en,
   output logic [7:0]  bus_sel,
   output logic [5:0]  gr_sel,
   output logic [3:0]  mem_ctl,
   output logic [4:0]  alu_op,
   output logic        run
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_NOP, C_ALU, C_IMM, C_LD, C_ST, C_BR, C_JR, C_IN, C_OUT,
      C_MFHI, C_MFLO, C_HALT, C_MULDIV
   } cls_t;

   // Field order matches the concatenation of the output ports.
   typedef struct packed {
      logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in;
      logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, inport_out, c_out;
      logic gra, grb, grc, r_in, r_out, ba_out;
      logic rd, wr, inc_pc, con_in;
      logic [4:0] alu;
   } ctl_t;

   localparam logic [4:0] OP_ADD = 5'b00011;

   state_t     state;
   cls_t       cls;
   ctl_t       ctl;
   logic [4:0] opcode;
   logic       unused_ir;

   assign opcode    = ir[31:27];
   assign unused_ir = ^ir[26:0];

   always_comb begin
      case (opcode)
         5'b00011, 5'b00100, 5'b00101,
         5'b00110, 5'b00111, 5'b01000: cls = C_ALU;
         5'b00001, 5'b01100:           cls = C_IMM;
         5'b00000:                     cls = C_LD;
         5'b00010:                     cls = C_ST;
         5'b10010:                     cls = C_BR;
         5'b10011:                     cls = C_JR;
         5'b10101:                     cls = C_IN;
         5'b10110:                     cls = C_OUT;
         5'b10111:                     cls = C_MFHI;
         5'b11000:                     cls = C_MFLO;
         5'b11010:                     cls = C_HALT;
`ifdef CU_MULDIV_EN
         5'b01111, 5'b10000:           cls = C_MULDIV;
`endif
         default:                      cls = C_NOP;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every reader sees the pre-edge value.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= S_RESET;
      end else begin
         case (state)
            S_RESET: state <= S_T0;
            S_T0:    state <= stop ? S_HALT : S_T1;
            S_T1:    state <= S_T2;
            S_T2:    state <= S_T3;
            S_T3: begin
               case (cls)
                  C_HALT:                                   state <= S_HALT;
                  C_ALU, C_IMM, C_LD, C_ST, C_BR, C_MULDIV: state <= S_T4;
                  default:                                  state <= S_T0;
               endcase
            end
            S_T4:    state <= S_T5;
            S_T5:    state <= (cls inside {C_LD, C_ST, C_BR, C_MULDIV}) ? S_T6 : S_T0;
            S_T6:    state <= (cls inside {C_LD, C_ST}) ? S_T7 : S_T0;
            S_T7:    state <= S_T0;
            S_HALT:  state <= S_HALT;
            default: state <= S_RESET;
         endcase
      end
   end

   // Strobes decode from the live state and opcode: IR is only loaded at the end of T2,
   // so a registered decode would act on the previous instruction in T3.
   always_comb begin
      // NOTE: clear the whole control word first so no path through the case infers a latch.
      ctl = '0;
      case (state)
         S_T0: if (!stop) begin
            ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
         end
         S_T1: begin
            ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.rd = 1'b1; ctl.mdr_in = 1'b1;
         end
         S_T2: begin
            ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_ALU:               begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
               C_IMM, C_LD, C_ST:   begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
               C_BR:                begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
               C_JR:                begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
               C_IN:                begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
               C_OUT:               begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; end
               C_MFHI:              begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
               C_MFLO:              begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
               C_MULDIV:            begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
               default:             ;
            endcase
         end
         S_T4: begin
            case (cls)
               C_ALU:             begin ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu = opcode; end
               C_IMM, C_LD, C_ST: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu = OP_ADD; end
               C_BR:              begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
               C_MULDIV:          begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; ctl.alu = opcode; end
               default:           ;
            endcase
         end
         S_T5: begin
            case (cls)
               C_ALU, C_IMM: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
               C_LD, C_ST:   begin ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1; end
               C_BR:         begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu = OP_ADD; end
               C_MULDIV:     begin ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1; end
               default:      ;
            endcase
         end
         S_T6: begin
            case (cls)
               C_LD:     begin ctl.rd = 1'b1; ctl.mdr_in = 1'b1; end
               C_ST:     begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; end
               C_BR:     if (con_ff) begin ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; end
               C_MULDIV: begin ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1; end
               default:  ;
            endcase
         end
         S_T7: begin
            case (cls)
               C_LD:    begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
               C_ST:    ctl.wr = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign {ld_en, bus_sel, gr_sel, mem_ctl, alu_op} = ctl;
   assign run = (state != S_RESET) && (state != S_HALT);

endmodule
